// File: rtl/fd_sched_pkg.sv
// Shared types and constants for the face-detection frame scheduler.
// Holds the scheduler state encoding and the frame-size rules.
package fd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DISPATCH,
    DRAIN,
    DONE
  } state_t;

  // A core needs unit_size >= 3 or its filter_height collapses to zero.
  localparam int MIN_UNIT_SIZE = 3;
  localparam int UNIT_SHIFT    = 3;

  // Index width that stays legal for a single-entry range.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fd_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the
// rotating pointer; the pointer moves past the winner only on an accepted grant.
module fd_rr_arbiter
  import fd_sched_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  localparam int ID_W      = id_width(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] eligible,
  input  logic                 accept,
  output logic [NUM_CORES-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 any_grant
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;

  // NOTE: every output gets a default before the search loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_CORES);
      if (!any_grant && eligible[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept && any_grant) begin
      ptr <= (int'(grant_id) == NUM_CORES - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fd_tile_scheduler.sv
// Frame-level tile scheduler: splits a frame into TILES_X x TILES_Y tiles,
// dispatches them round-robin to free detection cores and reports completion.
module fd_tile_scheduler
  import fd_sched_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  parameter  int TILES_X   = 3,
  parameter  int TILES_Y   = 3,
  parameter  int SIZE_W    = 32,
  localparam int ID_W      = id_width(NUM_CORES),
  localparam int X_W       = id_width(TILES_X),
  localparam int Y_W       = id_width(TILES_Y)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [SIZE_W-1:0]    size,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 disp_valid,
  output logic [ID_W-1:0]      disp_core,
  output logic [X_W-1:0]       disp_tile_x,
  output logic [Y_W-1:0]       disp_tile_y,
  output logic [SIZE_W-1:0]    unit_size,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 err_size,
  output logic                 err_spurious
);

  localparam int NUM_TILES = TILES_X * TILES_Y;
  localparam int CNT_W     = $clog2(NUM_TILES + 1);

  state_t                 state, state_nxt;
  logic [NUM_CORES-1:0]   busy;
  logic [NUM_CORES-1:0]   done_ok;
  logic [NUM_CORES-1:0]   spurious;
  logic [NUM_CORES-1:0]   eligible;
  logic [NUM_CORES-1:0]   grant;
  logic [ID_W-1:0]        grant_id;
  logic                   any_grant;
  logic [X_W-1:0]         tile_x;
  logic [Y_W-1:0]         tile_y;
  logic [CNT_W-1:0]       done_cnt;
  logic                   reject;
  logic                   accept_frame;
  logic                   dispatching;
  logic                   last_tile;
  logic [SIZE_W-1:0]      size_unit;
  logic                   size_bad;

  assign size_unit    = size >> UNIT_SHIFT;
  assign size_bad     = size_unit < SIZE_W'(MIN_UNIT_SIZE);
  assign accept_frame = (state == IDLE) && frame_start;
  assign done_ok      = core_done & busy;
  assign spurious     = core_done & ~busy;
  // A core finishing this cycle is still marked busy, so it waits one cycle.
  assign eligible     = core_ready & ~busy;
  // Arbitration starts in SETUP so the first dispatch is visible two cycles after frame_start.
  assign dispatching  = ((state == SETUP) && !reject) || (state == DISPATCH);
  assign last_tile    = (tile_x == X_W'(TILES_X - 1)) && (tile_y == Y_W'(TILES_Y - 1));

  fd_rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .eligible  (eligible),
    .accept    (dispatching),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (frame_start) state_nxt = SETUP;
      SETUP: begin
        if (reject)                      state_nxt = IDLE;
        else if (any_grant && last_tile) state_nxt = DRAIN;
        else                             state_nxt = DISPATCH;
      end
      DISPATCH: if (any_grant && last_tile) state_nxt = DRAIN;
      DRAIN:    if (busy == '0 && done_cnt == CNT_W'(NUM_TILES)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy         <= '0;
      tile_x       <= '0;
      tile_y       <= '0;
      done_cnt     <= '0;
      reject       <= 1'b0;
      disp_valid   <= 1'b0;
      disp_core    <= '0;
      disp_tile_x  <= '0;
      disp_tile_y  <= '0;
      unit_size    <= '0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      err_size     <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      disp_valid   <= dispatching && any_grant;
      frame_busy   <= (state_nxt != IDLE);
      frame_done   <= (state == DRAIN) && (state_nxt == DONE);
      err_size     <= accept_frame && size_bad;
      err_spurious <= (accept_frame ? 1'b0 : err_spurious) | (|spurious);
      busy         <= (busy & ~done_ok) | (dispatching ? grant : '0);
      done_cnt     <= done_cnt + CNT_W'($countones(done_ok));

      if (accept_frame) begin
        unit_size <= size_unit;
        reject    <= size_bad;
        tile_x    <= '0;
        tile_y    <= '0;
        done_cnt  <= '0;
      end

      if (dispatching && any_grant) begin
        disp_core   <= grant_id;
        disp_tile_x <= tile_x;
        disp_tile_y <= tile_y;
        if (tile_x == X_W'(TILES_X - 1)) begin
          tile_x <= '0;
          tile_y <= tile_y + 1'b1;
        end else begin
          tile_x <= tile_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fd_tile_scheduler.sv
// Self-checking bench for fd_tile_scheduler: table-driven frame vectors, a
// dispatch scoreboard, an auto-responding core model and hand-written corner cases.
module tb_fd_tile_scheduler;

  localparam int NC  = 4;
  localparam int TX  = 3;
  localparam int TY  = 3;
  localparam int SW  = 32;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [SW-1:0] size = '0;
  logic [NC-1:0] core_ready = '0;
  logic [NC-1:0] man_done = '0;
  logic [NC-1:0] auto_done = '0;
  logic [NC-1:0] core_done;
  logic          disp_valid;
  logic [1:0]    disp_core;
  logic [1:0]    disp_tile_x;
  logic [1:0]    disp_tile_y;
  logic [SW-1:0] unit_size;
  logic          frame_busy;
  logic          frame_done;
  logic          err_size;
  logic          err_spurious;

  assign core_done = man_done | auto_done;

  always #5 clk = ~clk;

  fd_tile_scheduler #(
    .NUM_CORES (NC),
    .TILES_X   (TX),
    .TILES_Y   (TY),
    .SIZE_W    (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .size         (size),
    .core_ready   (core_ready),
    .core_done    (core_done),
    .disp_valid   (disp_valid),
    .disp_core    (disp_core),
    .disp_tile_x  (disp_tile_x),
    .disp_tile_y  (disp_tile_y),
    .unit_size    (unit_size),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .err_size     (err_size),
    .err_spurious (err_spurious)
  );

  typedef struct {
    logic [1:0] core;
    logic [1:0] x;
    logic [1:0] y;
  } disp_t;

  typedef struct {
    logic [SW-1:0] size;
    logic [SW-1:0] unit;
    bit            err;
  } vec_t;

  disp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    auto_en = 1'b0;
  int    cnt[NC] = '{default: 0};
  int    frame_done_seen = 0;
  int    exp_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected dispatch order when core latency exceeds the number of eligible cores:
  // strict rotation over the ready cores starting at the arbiter pointer.
  task automatic push_frame(input logic [NC-1:0] ready);
    int p;
    int c;
    p = exp_ptr;
    for (int t = 0; t < TX * TY; t++) begin
      c = p;
      for (int k = 0; k < NC; k++) begin
        if (ready[(p + k) % NC]) begin
          c = (p + k) % NC;
          break;
        end
      end
      exp_q.push_back('{core: 2'(c), x: 2'(t % TX), y: 2'(t / TX)});
      p = (c + 1) % NC;
    end
    exp_ptr = p;
  endtask

  // Dispatch monitor, scoreboard and core model; all sampling on the falling edge.
  initial begin
    disp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        auto_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) auto_done[i] = 1'b1;
        end
      end
      if (frame_done) frame_done_seen++;
      if (disp_valid) begin
        check("dispatch_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("disp_core", 64'(disp_core), 64'(e.core));
          check("disp_tile_x", 64'(disp_tile_x), 64'(e.x));
          check("disp_tile_y", 64'(disp_tile_y), 64'(e.y));
        end
        if (auto_en) cnt[int'(disp_core)] = LAT;
      end
    end
  end

  task automatic run_frame(input logic [SW-1:0] sz, input logic [SW-1:0] exp_unit,
                           input bit exp_err, input string tag);
    bit got;
    if (!exp_err) push_frame(core_ready);
    @(negedge clk);
    frame_start = 1'b1;
    size        = sz;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, "_err_size_n1"}, 64'(err_size), 64'(exp_err));
    check({tag, "_unit_size"}, 64'(unit_size), 64'(exp_unit));
    check({tag, "_busy_n1"}, 64'(frame_busy), 64'd1);
    check({tag, "_spurious_clr"}, 64'(err_spurious), 64'd0);
    check({tag, "_disp_n1"}, 64'(disp_valid), 64'd0);
    @(negedge clk);
    if (exp_err) begin
      check({tag, "_busy_n2"}, 64'(frame_busy), 64'd0);
      check({tag, "_err_size_n2"}, 64'(err_size), 64'd0);
      check({tag, "_disp_n2"}, 64'(disp_valid), 64'd0);
    end else begin
      check({tag, "_disp_n2"}, 64'(disp_valid), 64'd1);
      got = 1'b0;
      for (int k = 0; k < 500 && !got; k++) begin
        @(negedge clk);
        if (frame_done) got = 1'b1;
      end
      check({tag, "_frame_done_seen"}, 64'(got), 64'd1);
      if (got) begin
        check({tag, "_busy_at_done"}, 64'(frame_busy), 64'd1);
        check({tag, "_unit_held"}, 64'(unit_size), 64'(exp_unit));
        @(negedge clk);
        check({tag, "_busy_after_done"}, 64'(frame_busy), 64'd0);
        check({tag, "_done_single"}, 64'(frame_done), 64'd0);
      end
    end
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    int   ok_frames;
    int   done_before;

    vecs[0] = '{size: 32'd96,          unit: 32'd12,          err: 1'b0};
    vecs[1] = '{size: 32'd100,         unit: 32'd12,          err: 1'b0};
    vecs[2] = '{size: 32'd16,          unit: 32'd2,           err: 1'b1};
    vecs[3] = '{size: 32'd24,          unit: 32'd3,           err: 1'b0};
    vecs[4] = '{size: 32'd23,          unit: 32'd2,           err: 1'b1};
    vecs[5] = '{size: 32'd0,           unit: 32'd0,           err: 1'b1};
    vecs[6] = '{size: 32'hFFFF_FFFF,   unit: 32'h1FFF_FFFF,   err: 1'b0};
    ok_frames = 0;

    // Reset state
    reset      = 1'b0;
    core_ready = '1;
    repeat (3) @(negedge clk);
    check("rst_disp_valid", 64'(disp_valid), 64'd0);
    check("rst_disp_core", 64'(disp_core), 64'd0);
    check("rst_unit_size", 64'(unit_size), 64'd0);
    check("rst_frame_busy", 64'(frame_busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_err_size", 64'(err_size), 64'd0);
    check("rst_err_spurious", 64'(err_spurious), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Spurious completion while idle: sticky flag, no frame_done
    man_done = 4'b1000;
    @(negedge clk);
    man_done = '0;
    check("spurious_set", 64'(err_spurious), 64'd1);
    repeat (5) @(negedge clk);
    check("spurious_sticky", 64'(err_spurious), 64'd1);
    check("spurious_no_done", 64'(frame_done_seen), 64'd0);

    // Frame vectors with all cores ready and the auto core model
    auto_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].size, vecs[v].unit, vecs[v].err, $sformatf("vec%0d", v));
      if (!vecs[v].err) ok_frames++;
      repeat (2) @(negedge clk);
    end

    // Only cores 0 and 2 ready: dispatch alternates between them
    core_ready = 4'b0101;
    run_frame(32'd96, 32'd12, 1'b0, "fair");
    ok_frames++;
    repeat (2) @(negedge clk);

    // Same-cycle completion: core 1 alone, done and re-grant one cycle apart
    auto_en    = 1'b0;
    core_ready = 4'b0010;
    exp_q.push_back('{core: 2'd1, x: 2'd0, y: 2'd0});
    exp_q.push_back('{core: 2'd1, x: 2'd1, y: 2'd0});
    @(negedge clk);
    frame_start = 1'b1;
    size        = 32'd96;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("sc_first_disp", 64'(disp_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("sc_stall", 64'(disp_valid), 64'd0);
    check("sc_busy", 64'(frame_busy), 64'd1);
    man_done = 4'b0010;
    @(negedge clk);
    man_done = '0;
    check("sc_no_grant_same_cycle", 64'(disp_valid), 64'd0);
    @(negedge clk);
    check("sc_grant_next_cycle", 64'(disp_valid), 64'd1);
    check("sc_grant_core", 64'(disp_core), 64'd1);

    // Reset mid-DISPATCH aborts silently
    done_before = frame_done_seen;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_disp_valid", 64'(disp_valid), 64'd0);
    check("mid_rst_disp_tile_x", 64'(disp_tile_x), 64'd0);
    check("mid_rst_unit_size", 64'(unit_size), 64'd0);
    check("mid_rst_frame_busy", 64'(frame_busy), 64'd0);
    check("mid_rst_err_size", 64'(err_size), 64'd0);
    check("mid_rst_err_spurious", 64'(err_spurious), 64'd0);
    reset   = 1'b1;
    exp_ptr = 0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 64'(frame_done_seen), 64'(done_before));
    check("mid_rst_idle_busy", 64'(frame_busy), 64'd0);

    // Nominal frame after reset: cores 0,1,2,3 then reuse in completion order
    core_ready = '1;
    auto_en    = 1'b1;
    run_frame(32'd96, 32'd12, 1'b0, "nominal");
    ok_frames++;

    repeat (5) @(negedge clk);
    check("total_frame_done", 64'(frame_done_seen), 64'(ok_frames));
    check("final_spurious", 64'(err_spurious), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
